// File: rtl/vga_sync_gen_if.sv
// Signal bundle from the VGA timing generator to the DAC pins and pixel logic.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_sync_gen_if;
    logic       vgaClk;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       sync_n;
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    logic       pix_tick;
    logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    modport master (
        output vgaClk, hsync, vsync, blank_n, sync_n, active,
        output x, y, pix_tick, frame_start
`ifdef VGA_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        input vgaClk, hsync, vsync, blank_n, sync_n, active,
        input x, y, pix_tick, frame_start
`ifdef VGA_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator on the system clock with an internal divide-by-DIV pixel tick.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen #(
    parameter int DIV      = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START  = H_ACTIVE + H_FP;
    localparam int HS_END    = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START  = V_ACTIVE + V_FP;
    localparam int VS_END    = V_ACTIVE + V_FP + V_SYNC;
    localparam int DIV_W     = (DIV > 2) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_next_s;
    logic [9:0]       hcnt_r;
    logic [9:0]       vcnt_r;
    logic             vga_clk_r;
    logic             pix_tick_s;
    logic             line_end_s;
    logic             frame_end_s;
    logic             active_s;
    logic             hsync_s;
    logic             vsync_s;

    // Decode of the registered counters; all outputs valid in the same cycle.
    always_comb begin
        pix_tick_s  = (div_cnt_r == DIV_W'(DIV - 1));
        div_next_s  = pix_tick_s ? '0 : div_cnt_r + DIV_W'(1);
        line_end_s  = (hcnt_r == 10'(H_TOTAL - 1));
        frame_end_s = pix_tick_s && line_end_s && (vcnt_r == 10'(V_TOTAL - 1));
        active_s    = (hcnt_r < 10'(H_ACTIVE)) && (vcnt_r < 10'(V_ACTIVE));
        hsync_s     = !((hcnt_r >= 10'(HS_START)) && (hcnt_r < 10'(HS_END)));
        vsync_s     = !((vcnt_r >= 10'(VS_START)) && (vcnt_r < 10'(VS_END)));
    end

    // Pixel divider; vgaClk is registered from the next divider value so it never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_r <= '0;
            vga_clk_r <= 1'b0;
        end else begin
            div_cnt_r <= div_next_s;
            vga_clk_r <= (div_next_s >= DIV_W'(DIV / 2));
        end
    end

    // Raster counters advance only on the pixel tick; reset wins over a coincident tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_r <= 10'd0;
            vcnt_r <= 10'd0;
        end else if (pix_tick_s) begin
            if (line_end_s) begin
                hcnt_r <= 10'd0;
                vcnt_r <= (vcnt_r == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt_r + 10'd1;
            end else begin
                hcnt_r <= hcnt_r + 10'd1;
                vcnt_r <= vcnt_r;
            end
        end else begin
            hcnt_r <= hcnt_r;
            vcnt_r <= vcnt_r;
        end
    end

    assign vga.vgaClk      = vga_clk_r;
    assign vga.hsync       = hsync_s;
    assign vga.vsync       = vsync_s;
    assign vga.blank_n     = active_s;
    assign vga.sync_n      = 1'b0;
    assign vga.active      = active_s;
    assign vga.x           = active_s ? hcnt_r : 10'd0;
    assign vga.y           = active_s ? vcnt_r : 10'd0;
    assign vga.pix_tick    = pix_tick_s;
    assign vga.frame_start = frame_end_s;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frame counter for pattern animation, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_end_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign vga.frame_cnt = frame_cnt_r;
`endif
endmodule
